// File: rtl/ste_avg_pkg.sv
// Shared definitions for the multi-channel exponential averager:
// FSM state encoding and width helper functions.
package ste_avg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Accumulator width: sample bits plus fractional guard bits.
   function automatic int calc_acc_w(input int data_w, input int frac_w);
      return data_w + frac_w;
   endfunction

   // Channel index width; at least one bit even for a single channel.
   function automatic int calc_ch_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/ste_avg_iir_core.sv
// Combinational update of one channel accumulator (alpha = 2^-k) and
// derivation of the output sample. Optional macro STE_AVG_IIR_ROUND_EN
// selects round-half-up output with saturation instead of truncation.
module ste_avg_iir_core
   import ste_avg_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int FRAC_W  = 8,
   parameter  int SHIFT_W = 4,
   localparam int ACC_W   = calc_acc_w(DATA_W, FRAC_W)
) (
   input  logic [DATA_W-1:0]  din_i,
   input  logic [ACC_W-1:0]   acc_i,
   input  logic               primed_i,
   input  logic               avg_en_i,
   input  logic [SHIFT_W-1:0] shift_i,
   output logic [ACC_W-1:0]   acc_o,
   output logic [DATA_W-1:0]  dout_o
);

   logic [ACC_W-1:0]        w_din_ext;
   logic signed [ACC_W:0]   w_diff;
   logic signed [ACC_W:0]   w_step;
   logic [ACC_W:0]          w_sum;

   // Accumulator update: load on unprimed/bypass, else add shifted error.
   always_comb begin
      w_din_ext = ACC_W'(din_i) << FRAC_W;
      w_diff    = $signed({1'b0, w_din_ext}) - $signed({1'b0, acc_i});
      w_step    = w_diff >>> shift_i;
      w_sum     = {1'b0, acc_i} + $unsigned(w_step);
      if (!primed_i || !avg_en_i) begin
         acc_o = w_din_ext;
      end else if (32'(shift_i) >= ACC_W) begin
         // a shift this large would leave -1 for negative errors; hold instead
         acc_o = acc_i;
      end else begin
         acc_o = ACC_W'(w_sum);
      end
   end

`ifdef STE_AVG_IIR_ROUND_EN
   localparam logic [ACC_W:0] HALF = (FRAC_W > 0) ?
      ((ACC_W+1)'(1) << ((FRAC_W > 0) ? (FRAC_W - 1) : 0)) : (ACC_W+1)'(0);
   localparam logic [ACC_W:0] MAXV = (ACC_W+1)'({DATA_W{1'b1}});
   logic [ACC_W:0] w_q;

   // Round-half-up output, saturated to the largest sample value.
   always_comb begin
      w_q = ({1'b0, acc_o} + HALF) >> FRAC_W;
      if (w_q > MAXV) begin
         dout_o = {DATA_W{1'b1}};
      end else begin
         dout_o = DATA_W'(w_q);
      end
   end
`else
   // Truncating output: drop the fractional bits.
   always_comb begin
      dout_o = DATA_W'(acc_o >> FRAC_W);
   end
`endif

endmodule

// File: rtl/ste_avg_iir_mc.sv
// Multi-channel exponential moving average, one sample per three cycles.
// FSM IDLE -> CALC -> OUT; per-channel accumulator and primed flag.
// Optional macro STE_AVG_IIR_ROUND_EN enables rounded output (see core).
module ste_avg_iir_mc
   import ste_avg_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int N_CH    = 4,
   parameter  int FRAC_W  = 8,
   parameter  int SHIFT_W = 4,
   localparam int CH_W    = calc_ch_w(N_CH),
   localparam int ACC_W   = calc_acc_w(DATA_W, FRAC_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  din_i,
   input  logic [CH_W-1:0]    din_ch_i,
   input  logic               din_valid_i,
   output logic               din_ready_o,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic               avg_en_i,
   input  logic               avg_clr_i,
   output logic [DATA_W-1:0]  dout_o,
   output logic [CH_W-1:0]    dout_ch_o,
   output logic               dout_valid_o
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;

   logic [ACC_W-1:0]     r_acc [N_CH];
   logic [N_CH-1:0]      r_primed;
   logic [DATA_W-1:0]    r_din;
   logic [CH_W-1:0]      r_ch;
   logic [SHIFT_W-1:0]   r_shift;
   logic                 r_avg_en;
   logic [DATA_W-1:0]    r_dout;
   logic [CH_W-1:0]      r_dout_ch;
   logic                 r_dout_valid;

   logic [ACC_W-1:0]     w_acc_new;
   logic [DATA_W-1:0]    w_dout_new;

   assign din_ready_o  = (r_state == ST_IDLE);
   assign w_accept     = din_valid_i && (r_state == ST_IDLE);
   assign dout_o       = r_dout;
   assign dout_ch_o    = r_dout_ch;
   assign dout_valid_o = r_dout_valid;

   ste_avg_iir_core #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .SHIFT_W (SHIFT_W)
   ) u_core (
      .din_i    (r_din),
      .acc_i    (r_acc[r_ch]),
      .primed_i (r_primed[r_ch]),
      .avg_en_i (r_avg_en),
      .shift_i  (r_shift),
      .acc_o    (w_acc_new),
      .dout_o   (w_dout_new)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a clear aborts whatever is in flight.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (din_valid_i) begin
               w_state_nxt = ST_CALC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CALC: w_state_nxt = ST_OUT;
         ST_OUT:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (avg_clr_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // Sample capture, channel state write-back and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_primed     <= '0;
         r_din        <= '0;
         r_ch         <= '0;
         r_shift      <= '0;
         r_avg_en     <= 1'b0;
         r_dout       <= '0;
         r_dout_ch    <= '0;
         r_dout_valid <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         r_dout_valid <= (r_state == ST_CALC) && !avg_clr_i;
         if (avg_clr_i) begin
            r_primed <= '0;
            for (int i = 0; i < N_CH; i++) begin
               r_acc[i] <= '0;
            end
         end else begin
            if (w_accept) begin
               r_din    <= din_i;
               r_ch     <= din_ch_i;
               r_shift  <= shift_i;
               r_avg_en <= avg_en_i;
            end
            if (r_state == ST_CALC) begin
               r_acc[r_ch]    <= w_acc_new;
               r_primed[r_ch] <= 1'b1;
               r_dout         <= w_dout_new;
               r_dout_ch      <= r_ch;
            end
         end
      end
   end

endmodule

// File: tb/tb_ste_avg_iir_mc.sv
// Self-checking bench for ste_avg_iir_mc (DATA_W=16, FRAC_W=8, N_CH=4).
module tb_ste_avg_iir_mc;

   localparam int FRAC = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din_i;
   logic [1:0]  din_ch_i;
   logic        din_valid_i;
   logic        din_ready_o;
   logic [3:0]  shift_i;
   logic        avg_en_i;
   logic        avg_clr_i;
   logic [15:0] dout_o;
   logic [1:0]  dout_ch_o;
   logic        dout_valid_o;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state: accumulator as real integer, primed flag
   longint m_acc [4];
   bit     m_pr  [4];

   always #5 clk = ~clk;

   ste_avg_iir_mc #(.DATA_W(16), .N_CH(4), .FRAC_W(8), .SHIFT_W(4)) dut (
      .clk(clk), .rst(rst), .din_i(din_i), .din_ch_i(din_ch_i),
      .din_valid_i(din_valid_i), .din_ready_o(din_ready_o), .shift_i(shift_i),
      .avg_en_i(avg_en_i), .avg_clr_i(avg_clr_i), .dout_o(dout_o),
      .dout_ch_o(dout_ch_o), .dout_valid_o(dout_valid_o)
   );

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic longint floor_div(input longint a, input int k);
      longint p;
      p = longint'(1) << k;
      if (a >= 0) return a / p;
      return -((-a + p - 1) / p);
   endfunction

   function automatic int model_out(input longint acc);
      longint v;
`ifdef STE_AVG_IIR_ROUND_EN
      v = (acc + 128) / 256;
      if (v > 65535) v = 65535;
`else
      v = acc / 256;
`endif
      return int'(v);
   endfunction

   function automatic int model_step(input int ch, input int din, input int k, input bit en);
      if (!m_pr[ch] || !en) begin
         m_acc[ch] = longint'(din) * 256;
         m_pr[ch]  = 1'b1;
         return din;
      end
      if (k < 24) m_acc[ch] = m_acc[ch] + floor_div(longint'(din) * 256 - m_acc[ch], k);
      return model_out(m_acc[ch]);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = 0;
         m_pr[i]  = 1'b0;
      end
   endfunction

   // one accepted sample, checks latency, value, channel, hold-after-strobe
   task automatic send(input int ch, input int din, input int k, input bit en, output int got);
      int w;
      int exp_d;
      w = 0;
      @(negedge clk);
      while (!din_ready_o && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (din_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready got=%b want=1", din_ready_o);
      end
      din_i = 16'(din); din_ch_i = 2'(ch); shift_i = 4'(k); avg_en_i = en;
      din_valid_i = 1'b1;
      @(negedge clk);
      din_valid_i = 1'b0;
      exp_d = model_step(ch, din, k, en);
      n_cmp++;
      if (dout_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL early_strobe got=%b want=0", dout_valid_o);
      end
      @(negedge clk);
      got = int'(dout_o);
      n_cmp++;
      if (dout_valid_o !== 1'b1 || dout_o !== 16'(exp_d) || dout_ch_o !== 2'(ch)) begin
         n_fail++;
         $display("FAIL strobe got v=%b d=%0d c=%0d want v=1 d=%0d c=%0d",
                  dout_valid_o, dout_o, dout_ch_o, exp_d, ch);
      end
      @(negedge clk);
      n_cmp++;
      if (dout_valid_o !== 1'b0 || dout_o !== 16'(exp_d) || dout_ch_o !== 2'(ch)) begin
         n_fail++;
         $display("FAIL hold got v=%b d=%0d c=%0d want v=0 d=%0d c=%0d",
                  dout_valid_o, dout_o, dout_ch_o, exp_d, ch);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_clear();
      n_cmp++;
      if (dout_o !== 16'd0 || dout_ch_o !== 2'd0 || dout_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got d=%0d c=%0d v=%b want 0 0 0", dout_o, dout_ch_o, dout_valid_o);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (din_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got=%b want=1", din_ready_o);
      end
   endtask

   task automatic test_prime_step_isolation();
      int g;
      int want_last;
`ifdef STE_AVG_IIR_ROUND_EN
      want_last = 938;
`else
      want_last = 937;
`endif
      send(0, 1000, 2, 1'b1, g);
      n_cmp++;
      if (g != 1000) begin n_fail++; $display("FAIL prime got=%0d want=1000", g); end
      send(1, 500, 2, 1'b1, g);
      n_cmp++;
      if (g != 500) begin n_fail++; $display("FAIL iso_ch1 got=%0d want=500", g); end
      send(0, 2000, 2, 1'b1, g);
      n_cmp++;
      if (g != 1250) begin n_fail++; $display("FAIL step1 got=%0d want=1250", g); end
      send(0, 0, 2, 1'b1, g);
      n_cmp++;
      if (g != want_last) begin n_fail++; $display("FAIL step2 got=%0d want=%0d", g, want_last); end
   endtask

   task automatic test_bypass();
      int g;
      send(2, 1234, 5, 1'b0, g);
      n_cmp++;
      if (g != 1234) begin n_fail++; $display("FAIL bypass got=%0d want=1234", g); end
      send(2, 1234, 3, 1'b1, g);
      n_cmp++;
      if (g != 1234) begin n_fail++; $display("FAIL k3_same got=%0d want=1234", g); end
      send(2, 40000, 0, 1'b1, g);
      n_cmp++;
      if (g != 40000) begin n_fail++; $display("FAIL k0 got=%0d want=40000", g); end
   endtask

   task automatic test_clear();
      int g;
      // clear while the sample is in CALC
      @(negedge clk);
      din_i = 16'd4321; din_ch_i = 2'd0; shift_i = 4'd1; avg_en_i = 1'b1; din_valid_i = 1'b1;
      @(negedge clk);
      din_valid_i = 1'b0;
      avg_clr_i = 1'b1;
      @(negedge clk);
      avg_clr_i = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (dout_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_no_strobe cyc=%0d got=%b want=0", i, dout_valid_o);
         end
         @(negedge clk);
      end
      send(0, 300, 2, 1'b1, g);
      n_cmp++;
      if (g != 300) begin n_fail++; $display("FAIL reprime got=%0d want=300", g); end
      send(1, 777, 4, 1'b1, g);
      n_cmp++;
      if (g != 777) begin n_fail++; $display("FAIL reprime_ch1 got=%0d want=777", g); end
      // clear coinciding with accept: sample dropped
      @(negedge clk);
      din_i = 16'd9999; din_ch_i = 2'd3; din_valid_i = 1'b1; avg_clr_i = 1'b1;
      @(negedge clk);
      din_valid_i = 1'b0; avg_clr_i = 1'b0;
      model_clear();
      n_cmp++;
      if (din_ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_accept_ready got=%b want=1", din_ready_o); end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (dout_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_accept_strobe got=%b want=0", dout_valid_o); end
   endtask

   task automatic test_random();
      int g;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 15) == 0) begin
            @(negedge clk);
            avg_clr_i = 1'b1;
            @(negedge clk);
            avg_clr_i = 1'b0;
            model_clear();
         end
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), g);
      end
   endtask

   task automatic test_back_to_back();
      int exp_d [$];
      int exp_c [$];
      int idx, last_c, n_out, ch, d;
      idx = 0; last_c = -1; n_out = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (idx == 12) din_valid_i = 1'b0;
         if (dout_valid_o === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra got d=%0d", dout_o);
            end else begin
               if (dout_o !== 16'(exp_d[0]) || dout_ch_o !== 2'(exp_c[0])) begin
                  n_fail++;
                  $display("FAIL b2b_data got d=%0d c=%0d want d=%0d c=%0d",
                           dout_o, dout_ch_o, exp_d[0], exp_c[0]);
               end
               void'(exp_d.pop_front());
               void'(exp_c.pop_front());
            end
            n_out++;
         end
         if (din_ready_o === 1'b1 && idx < 12) begin
            if (last_c >= 0) begin
               n_cmp++;
               if (c - last_c != 3) begin
                  n_fail++;
                  $display("FAIL b2b_spacing got=%0d want=3", c - last_c);
               end
            end
            last_c = c;
            ch = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 65535));
            din_i = 16'(d); din_ch_i = 2'(ch); shift_i = 4'd3; avg_en_i = 1'b1;
            din_valid_i = 1'b1;
            exp_d.push_back(model_step(ch, d, 3, 1'b1));
            exp_c.push_back(ch);
            idx++;
         end
         if (idx == 12 && exp_d.size() == 0) break;
      end
      din_valid_i = 1'b0;
      n_cmp++;
      if (n_out != 12) begin n_fail++; $display("FAIL b2b_count got=%0d want=12", n_out); end
   endtask

   task automatic test_reset_in_out();
      @(negedge clk);
      din_i = 16'd555; din_ch_i = 2'd3; shift_i = 4'd0; avg_en_i = 1'b0; din_valid_i = 1'b1;
      @(negedge clk);
      din_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dout_valid_o !== 1'b1 || dout_o !== 16'd555) begin
         n_fail++;
         $display("FAIL pre_rst_strobe got v=%b d=%0d want v=1 d=555", dout_valid_o, dout_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      n_cmp++;
      if (dout_o !== 16'd0 || dout_ch_o !== 2'd0 || dout_valid_o !== 1'b0 || din_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_in_out got d=%0d c=%0d v=%b r=%b want 0 0 0 1",
                  dout_o, dout_ch_o, dout_valid_o, din_ready_o);
      end
   endtask

   task automatic test_after_reset();
      int g;
      // channel 0 must be unprimed again after reset
      send(0, 4000, 4, 1'b1, g);
      n_cmp++;
      if (g != 4000) begin n_fail++; $display("FAIL post_rst_prime got=%0d want=4000", g); end
   endtask

   initial begin
      rst = 1'b1; din_i = '0; din_ch_i = '0; din_valid_i = 1'b0;
      shift_i = '0; avg_en_i = 1'b1; avg_clr_i = 1'b0;
      model_clear();
      test_reset();
      test_prime_step_isolation();
      test_bypass();
      test_clear();
      test_random();
      test_back_to_back();
      test_reset_in_out();
      test_after_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
